// File: rtl/axilite_read_channel.sv
// ---------------------------------------------------------------------------
// axilite_read_channel
//   AXI4-Lite slave read path (AR + R channels) that serves reads from a flat
//   bank of 32-bit registers supplied on the regs port.
//   One outstanding read at a time. araddr is a register word index.
//
//   Optional feature macro: AXIL_RD_RANGE_CHECK_EN
//     defined   : araddr >= NUM_REGS returns rdata=0 with SLVERR (2'b10)
//     undefined : index = low $clog2(NUM_REGS) bits of araddr (aliasing),
//                 rresp is always OKAY
// ---------------------------------------------------------------------------
module axilite_read_channel #(
    parameter int NUM_REGS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic [32*NUM_REGS-1:0]   regs
);

    // Width of the register index; guarded so a degenerate parameter still
    // elaborates to a legal vector.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Two-state FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic [0:0]  state_q,   state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;

    // Register bank unpacked into words so the read mux is a plain array index
    logic [31:0] reg_word [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
            assign reg_word[gi] = regs[32*gi +: 32];
        end
    endgenerate

    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      sel_data;
    logic [1:0]       sel_resp;

    assign rd_idx = araddr[IDX_W-1:0];

`ifdef AXIL_RD_RANGE_CHECK_EN
    localparam logic [31:0] NUM_REGS_U = NUM_REGS;

    logic addr_in_range;
    assign addr_in_range = (araddr < NUM_REGS_U);

    // Out-of-range reads return zero data with a slave error
    always_comb begin
        sel_data = 32'h0;
        sel_resp = RESP_SLVERR;
        if (addr_in_range) begin
            sel_data = reg_word[rd_idx];
            sel_resp = RESP_OKAY;
        end
    end
`else
    // Upper address bits deliberately ignored: addresses alias onto the bank
    logic unused_addr_bits;
    assign unused_addr_bits = ^araddr[31:IDX_W];

    // Every read is in range by construction
    always_comb begin
        sel_data = reg_word[rd_idx];
        sel_resp = RESP_OKAY;
    end
`endif

    // Next-state and output-next logic; all outputs come straight from flops
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (state_q)
            ST_IDLE: begin
                // arready rises one edge after reset release, then stays high
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                if (arvalid && arready_q) begin
                    // Snapshot the selected word; later regs changes are ignored
                    rdata_d   = sel_data;
                    rresp_d   = sel_resp;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b1;
                if (rready) begin
                    // rdata/rresp are left holding the completed read
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any pending read at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axilite_read_channel.sv
// ---------------------------------------------------------------------------
// tb_axilite_read_channel
//   Directed bench for axilite_read_channel (NUM_REGS=4). Inputs change and
//   outputs are sampled 1 ns after the rising edge.
//   Expected values for the out-of-range read follow AXIL_RD_RANGE_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_axilite_read_channel;

    localparam int NUM_REGS = 4;

    logic                   clk;
    logic                   rst;
    logic [31:0]            araddr;
    logic                   arvalid;
    logic                   arready;
    logic [31:0]            rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;
    logic [32*NUM_REGS-1:0] regs;

    int total = 0;
    int bad   = 0;

    axilite_read_channel #(.NUM_REGS(NUM_REGS)) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .regs    (regs)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp5_data;
        logic [31:0] exp5_resp;
`ifdef AXIL_RD_RANGE_CHECK_EN
        exp5_data = 32'h0;
        exp5_resp = 32'd2;
`else
        exp5_data = 32'h88776655;
        exp5_resp = 32'd0;
`endif

        rst     = 1'b1;
        araddr  = 32'd0;
        arvalid = 1'b0;
        rready  = 1'b0;
        regs    = 128'h8877665544332211;
        step();
        step();

        // Reset state
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_rdata",   rdata,            32'h0);
        chk("rst_rresp",   {30'b0, rresp},   32'd0);

        // Release: arready after the first edge
        rst = 1'b0;
        step();
        chk("rel_arready", {31'b0, arready}, 32'd1);
        chk("rel_rvalid",  {31'b0, rvalid},  32'd0);

        // Test 1: read word 0
        araddr = 32'd0; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t1_rvalid",  {31'b0, rvalid},  32'd1);
        chk("t1_arready", {31'b0, arready}, 32'd0);
        chk("t1_rdata",   rdata,            32'h44332211);
        chk("t1_rresp",   {30'b0, rresp},   32'd0);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("t1_done_rvalid",  {31'b0, rvalid},  32'd0);
        chk("t1_done_arready", {31'b0, arready}, 32'd1);

        // Test 2: read word 1, one wait cycle on rready
        araddr = 32'd1; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t2_rdata",   rdata,            32'h88776655);
        chk("t2_rresp",   {30'b0, rresp},   32'd0);
        chk("t2_arready", {31'b0, arready}, 32'd0);
        step();
        chk("t2_wait_arready", {31'b0, arready}, 32'd0);
        chk("t2_wait_rvalid",  {31'b0, rvalid},  32'd1);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("t2_done_arready", {31'b0, arready}, 32'd1);
        chk("t2_done_rvalid",  {31'b0, rvalid},  32'd0);

        // Test 3: stalled read keeps its snapshot while regs change
        araddr = 32'd0; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        regs[31:0] = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_rvalid", {31'b0, rvalid}, 32'd1);
            chk("t3_rdata",  rdata,           32'h44332211);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("t3_done_rvalid", {31'b0, rvalid}, 32'd0);
        regs[31:0] = 32'h44332211;

        // Test 4: back-to-back with rready held high
        rready = 1'b1;
        araddr = 32'd0; arvalid = 1'b1;
        step();
        chk("t4_a_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t4_a_rdata",  rdata,           32'h44332211);
        araddr = 32'd1;
        step();
        // Address 1 presented during DATA must not be taken on this edge
        chk("t4_gap_rvalid",  {31'b0, rvalid},  32'd0);
        chk("t4_gap_arready", {31'b0, arready}, 32'd1);
        chk("t4_gap_rdata",   rdata,            32'h44332211);
        step();
        chk("t4_b_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t4_b_rdata",  rdata,           32'h88776655);
        arvalid = 1'b0;
        step();
        chk("t4_done_rvalid", {31'b0, rvalid}, 32'd0);
        chk("t4_hold_rdata",  rdata,           32'h88776655);
        rready = 1'b0;

        // Test 5: address 5 (out of range / aliases to word 1)
        araddr = 32'd5; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t5_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t5_rdata",  rdata,           exp5_data);
        chk("t5_rresp",  {30'b0, rresp},  exp5_resp);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("t5_done_rvalid", {31'b0, rvalid}, 32'd0);

        // Test 6: reset while a read is pending
        araddr = 32'd1; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t6_pre_rvalid", {31'b0, rvalid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("t6_rst_arready", {31'b0, arready}, 32'd0);
        chk("t6_rst_rdata",   rdata,            32'h0);
        step();
        rst = 1'b0;
        #1;
        chk("t6_rel_arready0", {31'b0, arready}, 32'd0);
        step();
        chk("t6_rel_arready1", {31'b0, arready}, 32'd1);
        chk("t6_rel_rvalid",   {31'b0, rvalid},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
